// File: rtl/dwc_result_monitor.sv
// Result monitor for the duplicate-with-compare comparator: completes the
// done/ack handshake, tallies match/mismatch outcomes, tracks consecutive
// mismatches and raises sticky fault / protocol-error flags plus an irq.
module dwc_result_monitor #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned FAULT_THRESH = 3,
  parameter int unsigned ACK_TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      cmp_done,
  input  logic [31:0]      cmp_match,
  output logic [31:0]      cmp_ack,
  input  logic             clr_counts,
  input  logic             clr_fault,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [CNT_W-1:0] consec_mismatch,
  output logic             last_match,
  output logic             event_pulse,
  output logic             fault,
  output logic             proto_err,
  output logic             irq
);

  typedef enum logic [1:0] {IDLE, ACK, DRAIN} state_t;

  localparam int unsigned      TMO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] THRESH   = CNT_W'(FAULT_THRESH);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0]   mis_cnt_q, mis_cnt_d;
  logic [CNT_W-1:0]   consec_q, consec_d;
  logic               last_q, last_d;
  logic               pulse_q, pulse_d;
  logic               fault_q, fault_d;
  logic               perr_q, perr_d;
  logic               done;
  logic               fault_set;
  logic               perr_set;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Next-state, counter and flag logic; clear is applied before the captured event
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    match_cnt_d = match_cnt_q;
    mis_cnt_d   = mis_cnt_q;
    consec_d    = consec_q;
    last_d      = last_q;
    pulse_d     = 1'b0;
    fault_set   = 1'b0;
    perr_set    = 1'b0;
    done        = |cmp_done;

    if (clr_counts) begin
      match_cnt_d = '0;
      mis_cnt_d   = '0;
      consec_d    = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (done) begin
          pulse_d = 1'b1;
          tmo_d   = '0;
          state_d = ACK;
          last_d  = |cmp_match;
          if (|cmp_match) begin
            match_cnt_d = sat_inc(match_cnt_d);
            consec_d    = '0;
          end else begin
            mis_cnt_d = sat_inc(mis_cnt_d);
            consec_d  = sat_inc(consec_d);
            fault_set = (consec_d >= THRESH);
          end
        end
      end
      ACK: begin
        if (!done) begin
          state_d = IDLE;
        end else if (tmo_q == TMO_LAST) begin
          perr_set = 1'b1;
          state_d  = DRAIN;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DRAIN: begin
        if (!done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    fault_d = (fault_q & ~clr_fault) | fault_set;
    perr_d  = (perr_q & ~clr_fault) | perr_set;
  end

  // State and status registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      match_cnt_q <= '0;
      mis_cnt_q   <= '0;
      consec_q    <= '0;
      last_q      <= 1'b0;
      pulse_q     <= 1'b0;
      fault_q     <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      match_cnt_q <= match_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
      consec_q    <= consec_d;
      last_q      <= last_d;
      pulse_q     <= pulse_d;
      fault_q     <= fault_d;
      perr_q      <= perr_d;
    end
  end

  assign cmp_ack         = {31'd0, state_q == ACK};
  assign match_count     = match_cnt_q;
  assign mismatch_count  = mis_cnt_q;
  assign consec_mismatch = consec_q;
  assign last_match      = last_q;
  assign event_pulse     = pulse_q;
  assign fault           = fault_q;
  assign proto_err       = perr_q;
  assign irq             = fault_q | perr_q;

endmodule

// File: tb/tb_dwc_result_monitor.sv
// Bench for dwc_result_monitor: directed scenarios plus random traffic, with a
// transaction-level model compared against the DUT on every falling edge.
module tb_dwc_result_monitor;

  localparam int CNT_W = 4;
  localparam int TH    = 3;
  localparam int TO    = 64;
  localparam int MAXV  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [31:0]      cmp_done = '0;
  logic [31:0]      cmp_match = '0;
  logic             clr_counts = 1'b0;
  logic             clr_fault = 1'b0;
  logic [31:0]      cmp_ack;
  logic [CNT_W-1:0] match_count, mismatch_count, consec_mismatch;
  logic             last_match, event_pulse, fault, proto_err, irq;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // model state: counts as plain integers, handshake as "outstanding" + ack age
  int m_match = 0, m_mis = 0, m_consec = 0, m_age = 0;
  bit m_last = 0, m_pulse = 0, m_fault = 0, m_perr = 0, m_ack = 0, m_busy = 0;

  dwc_result_monitor #(.CNT_W(CNT_W), .FAULT_THRESH(TH), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .cmp_done(cmp_done), .cmp_match(cmp_match),
    .cmp_ack(cmp_ack), .clr_counts(clr_counts), .clr_fault(clr_fault),
    .match_count(match_count), .mismatch_count(mismatch_count),
    .consec_mismatch(consec_mismatch), .last_match(last_match),
    .event_pulse(event_pulse), .fault(fault), .proto_err(proto_err), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one result per done assertion, saturating tallies
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_match <= 0; m_mis <= 0; m_consec <= 0; m_age <= 0;
      m_last <= 0; m_pulse <= 0; m_fault <= 0; m_perr <= 0; m_ack <= 0; m_busy <= 0;
    end else begin : mdl
      int mm, mi, mc, ag;
      bit ls, pl, fs, ps, ak, bz;
      mm = m_match; mi = m_mis; mc = m_consec; ag = m_age;
      ls = m_last; ak = m_ack; bz = m_busy;
      pl = 0; fs = 0; ps = 0;
      if (clr_counts) begin mm = 0; mi = 0; mc = 0; end
      if (!bz) begin
        if (cmp_done != 0) begin
          bz = 1; ak = 1; ag = 0; pl = 1;
          if (cmp_match != 0) begin
            mm = (mm < MAXV) ? mm + 1 : MAXV; mc = 0; ls = 1;
          end else begin
            mi = (mi < MAXV) ? mi + 1 : MAXV;
            mc = (mc < MAXV) ? mc + 1 : MAXV;
            ls = 0;
            fs = (mc >= TH);
          end
        end
      end else if (cmp_done == 0) begin
        bz = 0; ak = 0;
      end else if (ak) begin
        ag = ag + 1;
        if (ag == TO) begin ak = 0; ps = 1; end
      end
      m_match <= mm; m_mis <= mi; m_consec <= mc; m_age <= ag;
      m_last <= ls; m_pulse <= pl; m_ack <= ak; m_busy <= bz;
      m_fault <= (m_fault && !clr_fault) || fs;
      m_perr  <= (m_perr && !clr_fault) || ps;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_match_count", 32'(match_count), 32'(m_match));
      check("cyc_mismatch_count", 32'(mismatch_count), 32'(m_mis));
      check("cyc_consec", 32'(consec_mismatch), 32'(m_consec));
      check("cyc_last_match", 32'(last_match), 32'(m_last));
      check("cyc_event_pulse", 32'(event_pulse), 32'(m_pulse));
      check("cyc_cmp_ack", cmp_ack, 32'(m_ack));
      check("cyc_fault", 32'(fault), 32'(m_fault));
      check("cyc_proto_err", 32'(proto_err), 32'(m_perr));
      check("cyc_irq", 32'(irq), 32'(m_fault | m_perr));
    end
  end

  // Full handshake; called and returns just after a falling edge
  task automatic hs(input bit mt, input int hold);
    int w;
    cmp_done  = 32'd1 << $urandom_range(0, 31);
    cmp_match = mt ? (32'd1 << $urandom_range(0, 31)) : 32'd0;
    w = 0;
    while (cmp_ack !== 32'd1 && w < 4) begin
      @(negedge clk);
      w++;
    end
    check("ack_latency", 32'(w), 32'd1);
    repeat (hold) @(negedge clk);
    #1 cmp_done = '0;
    @(negedge clk);
    check("ack_drop", cmp_ack, 32'd0);
    #1;
  endtask

  initial begin
    int n;
    bit d;
    #1 reset = 1'b0;
    #1 chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ack", cmp_ack, 32'd0);
    check("rst_match", 32'(match_count), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    #1 reset = 1'b1;

    // single match handshake
    hs(1'b1, 5);
    check("m1_match_count", 32'(match_count), 32'd1);
    check("m1_mismatch_count", 32'(mismatch_count), 32'd0);
    check("m1_last", 32'(last_match), 32'd1);

    // three mismatches reach the fault threshold
    repeat (3) hs(1'b0, 1);
    check("f_mis", 32'(mismatch_count), 32'd3);
    check("f_consec", 32'(consec_mismatch), 32'd3);
    check("f_fault", 32'(fault), 32'd1);
    check("f_irq", 32'(irq), 32'd1);
    hs(1'b1, 1);
    check("f_consec_after_match", 32'(consec_mismatch), 32'd0);
    check("f_fault_sticky", 32'(fault), 32'd1);
    clr_fault = 1'b1;
    @(negedge clk);
    check("f_cleared", 32'(fault), 32'd0);
    check("f_irq_cleared", 32'(irq), 32'd0);
    #1 clr_fault = 1'b0;

    // stuck done: ack times out, single count
    cmp_done = 32'h8000_0000; cmp_match = '0;
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (cmp_ack == 32'd1) n++;
    end
    check("to_ack_cycles", 32'(n), 32'(TO));
    check("to_proto_err", 32'(proto_err), 32'd1);
    check("to_irq", 32'(irq), 32'd1);
    check("to_mis_once", 32'(mismatch_count), 32'd4);
    #1 cmp_done = '0;
    @(negedge clk);
    #1;
    hs(1'b0, 2);
    check("to_second_capture", 32'(mismatch_count), 32'd5);
    clr_fault = 1'b1;
    @(negedge clk);
    #1 clr_fault = 1'b0;

    // saturation of match_count
    repeat (20) hs(1'b1, 0);
    check("sat_match", 32'(match_count), 32'(MAXV));

    // clear, then clear coincident with a mismatch capture
    clr_counts = 1'b1;
    @(negedge clk);
    check("clr_match", 32'(match_count), 32'd0);
    #1 clr_counts = 1'b0;
    repeat (7) hs(1'b1, 0);
    repeat (2) hs(1'b0, 0);
    check("pre_match", 32'(match_count), 32'd7);
    check("pre_mis", 32'(mismatch_count), 32'd2);
    cmp_done = 32'd4; cmp_match = '0; clr_counts = 1'b1;
    @(negedge clk);
    check("cc_match", 32'(match_count), 32'd0);
    check("cc_mis", 32'(mismatch_count), 32'd1);
    check("cc_consec", 32'(consec_mismatch), 32'd1);
    #1 clr_counts = 1'b0;
    repeat (2) @(negedge clk);
    #1 cmp_done = '0;
    repeat (2) @(negedge clk);
    #1;

    // reset in the middle of a handshake
    cmp_done = 32'd1; cmp_match = 32'd1;
    repeat (3) @(negedge clk);
    check("mid_ack_high", cmp_ack, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("mid_ack_async", cmp_ack, 32'd0);
    check("mid_mis_zero", 32'(mismatch_count), 32'd0);
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("mid_recapture_ack", cmp_ack, 32'd1);
    check("mid_recapture_cnt", 32'(match_count), 32'd1);
    check("mid_recapture_pulse", 32'(event_pulse), 32'd1);
    #1 cmp_done = '0;
    repeat (2) @(negedge clk);

    // random traffic
    d = 1'b0;
    repeat (600) begin
      #1;
      if ($urandom_range(0, 9) < 3) d = ~d;
      cmp_done   = d ? ($urandom | 32'd1) : 32'd0;
      cmp_match  = ($urandom_range(0, 2) != 0) ? $urandom : 32'd0;
      clr_counts = ($urandom_range(0, 19) == 0);
      clr_fault  = ($urandom_range(0, 29) == 0);
      @(negedge clk);
    end
    #1 cmp_done = '0; clr_counts = 1'b0; clr_fault = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
